// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: stage icodes/status in, stall/bubble controls,
// run state and performance counters out.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             start;
    logic [3:0]       D_icode;
    logic [3:0]       d_srcA;
    logic [3:0]       d_srcB;
    logic [3:0]       E_icode;
    logic [3:0]       E_dstM;
    logic             e_Cnd;
    logic [3:0]       M_icode;
    logic [3:0]       m_stat;
    logic [3:0]       W_stat;

    logic             F_stall;
    logic             D_stall;
    logic             W_stall;
    logic             D_bubble;
    logic             E_bubble;
    logic             M_bubble;
    logic             set_cc;
    logic [1:0]       run_state;
    logic [3:0]       proc_stat;
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] bub_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    // Pipeline side
    modport master (
        output start, D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, M_icode, m_stat, W_stat,
        input  F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc,
        input  run_state, proc_stat, cyc_cnt, stall_cnt, bub_cnt, mispred_cnt
    );

    // Controller side
    modport slave (
        input  start, D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, M_icode, m_stat, W_stat,
        output F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc,
        output run_state, proc_stat, cyc_cnt, stall_cnt, bub_cnt, mispred_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Y86-64 pipeline control: hazard detection, stall/bubble generation, run-state
// sequencing and saturating performance counters.
module pipe_hazard_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_hazard_ctrl_if.slave hz
);
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;
    localparam logic [3:0] S_AOK    = 4'h1;
    localparam logic [3:0] S_BUB    = 4'h8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_e;

    state_e           state_q;
    state_e           state_d;
    logic [3:0]       proc_stat_q;
    logic [CNT_W-1:0] cyc_q;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] bub_q;
    logic [CNT_W-1:0] mispred_q;

    logic lu_c;
    logic ret_c;
    logic mp_c;
    logic exc_m_c;
    logic exc_w_c;
    logic running_c;

    function automatic logic is_exc(input logic [3:0] s);
        return (s != S_AOK) && (s != S_BUB);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Raw hazard terms; gated by run state where they drive controls
    always_comb begin
        lu_c    = ((hz.E_icode == I_MRMOVQ) || (hz.E_icode == I_POPQ)) &&
                  (hz.E_dstM != R_NONE) &&
                  ((hz.E_dstM == hz.d_srcA) || (hz.E_dstM == hz.d_srcB));
        ret_c   = (hz.D_icode == I_RET) || (hz.E_icode == I_RET) || (hz.M_icode == I_RET);
        mp_c    = (hz.E_icode == I_JXX) && !hz.e_Cnd;
        exc_m_c = is_exc(hz.m_stat);
        exc_w_c = is_exc(hz.W_stat);
        running_c = (state_q == ST_RUN);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: HALTED is terminal until reset
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (hz.start) state_d = ST_RUN;
            ST_RUN:  if (exc_w_c)  state_d = ST_HALT;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    // Control outputs: frozen pipeline outside RUN; load/use outranks ret on D
    always_comb begin
        hz.F_stall  = 1'b1;
        hz.D_stall  = 1'b1;
        hz.W_stall  = 1'b1;
        hz.D_bubble = 1'b0;
        hz.E_bubble = 1'b0;
        hz.M_bubble = 1'b0;
        hz.set_cc   = 1'b0;
        if (running_c) begin
            hz.F_stall  = lu_c | ret_c;
            hz.D_stall  = lu_c;
            hz.W_stall  = exc_w_c;
            hz.D_bubble = mp_c | (ret_c & !lu_c);
            hz.E_bubble = mp_c | lu_c;
            hz.M_bubble = exc_m_c | exc_w_c;
            hz.set_cc   = (hz.E_icode == I_OPQ) & !exc_m_c & !exc_w_c;
        end
    end

    // Final status captured on the edge that enters HALTED
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proc_stat_q <= S_AOK;
        end else if (running_c && exc_w_c) begin
            proc_stat_q <= hz.W_stat;
        end
    end

    // Performance counters, active only in RUN (including the halting cycle)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q     <= '0;
            stall_q   <= '0;
            bub_q     <= '0;
            mispred_q <= '0;
        end else if (running_c) begin
            cyc_q <= sat_inc(cyc_q);
            if (hz.F_stall)                  stall_q   <= sat_inc(stall_q);
            if (hz.D_bubble | hz.E_bubble)   bub_q     <= sat_inc(bub_q);
            if (mp_c)                        mispred_q <= sat_inc(mispred_q);
        end
    end

    assign hz.run_state   = state_q;
    assign hz.proc_stat   = proc_stat_q;
    assign hz.cyc_cnt     = cyc_q;
    assign hz.stall_cnt   = stall_q;
    assign hz.bub_cnt     = bub_q;
    assign hz.mispred_cnt = mispred_q;
endmodule
